full_adder: RTL and testbench

//   Full-adder datapath cell: sums operands a, b and carry-in c, giving sum s and carry-out co.

---
 rtl/full_adder.sv | 72 +++++++
 tb/tb_full_adder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Ripple-carry full adder. Each bit is a 1-bit full-adder cell. The carry
// ripples LSB->MSB starting from c. An optional output register holds the
// result together with a valid flag.
module full_adder #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             out_valid
);

  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] sum_c;

  // Chain of 1-bit cells; k[i] is the carry into cell i, k[WIDTH] the carry-out.
  always_comb begin
    k     = '0;
    sum_c = '0;
    k[0]  = c;
    for (int i = 0; i < WIDTH; i++) begin
      sum_c[i] = a[i] ^ b[i] ^ k[i];
      k[i+1]   = (a[i] & b[i]) | (a[i] & k[i]) | (b[i] & k[i]);
    end
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] s_d, s_q;
    logic             co_d, co_q;
    logic             vld_d, vld_q;

    // Capture a new result on valid input; otherwise hold the sum and drop valid.
    always_comb begin
      s_d   = s_q;
      co_d  = co_q;
      vld_d = in_valid;
      if (in_valid) begin
        s_d  = sum_c;
        co_d = k[WIDTH];
      end
    end

    // Output register; reset clears any in-flight result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q   <= '0;
        co_q  <= 1'b0;
        vld_q <= 1'b0;
      end else begin
        s_q   <= s_d;
        co_q  <= co_d;
        vld_q <= vld_d;
      end
    end

    assign s         = s_q;
    assign co        = co_q;
    assign out_valid = vld_q;
  end else begin : g_comb
    // Pure gate-level path: clk is unused; the valid flag is gated by reset.
    assign s         = sum_c;
    assign co        = k[WIDTH];
    assign out_valid = in_valid & rst_n;
  end

endmodule

// File: tb/tb_full_adder.sv
`timescale 1ns/1ps
module tb_full_adder;

  logic clk;
  logic rst_n;

  // 1-bit registered instance
  logic       v1, a1, b1, c1;
  logic       s1, co1, ov1;
  // 4-bit registered instance
  logic       v4, c4;
  logic [3:0] a4, b4;
  logic [3:0] s4;
  logic       co4, ov4;
  // 1-bit combinational instance
  logic       vc, ac, bc, cc;
  logic       sc, coc, ovc;

  // Reference state: the arithmetic sum the registered outputs should hold.
  logic [1:0] exp1;
  logic       exp1_v;
  logic [4:0] exp4;
  logic       exp4_v;

  int n_pass  = 0;
  int n_total = 0;

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .c(c1),
    .s(s1), .co(co1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .c(c4),
    .s(s4), .co(co4), .out_valid(ov4)
  );

  full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .in_valid(vc), .a(ac), .b(bc), .c(cc),
    .s(sc), .co(coc), .out_valid(ovc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [1:0] comb_exp;
    comb_exp = 2'(ac) + 2'(bc) + 2'(cc);
    chk("w1_s",    32'(s1),  32'(exp1[0]));
    chk("w1_co",   32'(co1), 32'(exp1[1]));
    chk("w1_vld",  32'(ov1), 32'(exp1_v));
    chk("w4_s",    32'(s4),  32'(exp4[3:0]));
    chk("w4_co",   32'(co4), 32'(exp4[4]));
    chk("w4_vld",  32'(ov4), 32'(exp4_v));
    chk("comb_sum", 32'({coc, sc}), 32'(comb_exp));
    chk("comb_vld", 32'(ovc), 32'(vc & rst_n));
  endtask

  // Advance one rising edge, update the reference, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (v1) exp1 = 2'(a1) + 2'(b1) + 2'(c1);
      exp1_v = v1;
      if (v4) exp4 = 5'(a4) + 5'(b4) + 5'(c4);
      exp4_v = v4;
    end
    #1;
  endtask

  task automatic clear_ref();
    exp1 = '0; exp1_v = 1'b0;
    exp4 = '0; exp4_v = 1'b0;
  endtask

  initial begin
    logic [2:0] abc;
    rst_n = 1'b1;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    vc = 1'b1; ac = 1'b1; bc = 1'b1; cc = 1'b1;
    clear_ref();

    // Reset held with valid, all-ones inputs and the clock running.
    #1 rst_n = 1'b0;
    clear_ref();
    #1 check_all();
    repeat (3) begin
      tick();
      check_all();
    end

    // Release between edges; first result on the next valid edge.
    @(negedge clk);
    rst_n = 1'b1;
    v4 = 1'b0;

    // Exhaustive 1-bit truth table, 000..111.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      abc = 3'(i);
      v1 = 1'b1; a1 = abc[2]; b1 = abc[1]; c1 = abc[0];
      ac = abc[2]; bc = abc[1]; cc = abc[0];
      tick();
      check_all();
    end

    // Hold: capture 1+1+0, then drop valid.
    @(negedge clk);
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    tick();
    check_all();
    chk("hold_pre_co", 32'(co1), 32'd1);
    @(negedge clk);
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b1;
    tick();
    check_all();
    chk("hold_co", 32'(co1), 32'd1);
    chk("hold_vld", 32'(ov1), 32'd0);

    // Ripple directed vectors.
    @(negedge clk);
    v4 = 1'b1; a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    tick();
    check_all();
    chk("rip_f0_1", 32'({co4, s4}), 32'h10);
    @(negedge clk);
    a4 = 4'h9; b4 = 4'h6; c4 = 1'b0;
    tick();
    check_all();
    chk("rip_96_0", 32'({co4, s4}), 32'h0F);
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    tick();
    check_all();
    chk("rip_max", 32'({co4, s4}), 32'h1F);

    // Randomised traffic with random valid gaps.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      v1 = 1'($urandom_range(0, 1)); a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      v4 = 1'($urandom_range(0, 1)); a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      vc = 1'($urandom_range(0, 1)); ac = 1'($urandom); bc = 1'($urandom); cc = 1'($urandom);
      tick();
      check_all();
    end

    // Async reset pulse between edges with a result present and another pending.
    @(negedge clk);
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    v4 = 1'b1; a4 = 4'h7; b4 = 4'h8; c4 = 1'b1;
    vc = 1'b1;
    tick();
    check_all();
    #2 rst_n = 1'b0;
    clear_ref();
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    v1 = 1'b0; v4 = 1'b0;
    tick();
    check_all();

    // Combinational instance responds without any clock edge.
    @(negedge clk);
    #1;
    vc = 1'b1; ac = 1'b1; bc = 1'b0; cc = 1'b1;
    #1;
    chk("comb_s",   32'(sc),  32'd0);
    chk("comb_co",  32'(coc), 32'd1);
    chk("comb_ov",  32'(ovc), 32'd1);
    ac = 1'b1; bc = 1'b1; cc = 1'b1;
    #1;
    chk("comb_max", 32'({coc, sc}), 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
